seq_multiplier: RTL and testbench

- Parametrised sequential shift-add multiplier. Generalises the team's fixed 4-bit combinational multiplier to any operand width WIDTH.
- Processes one multiplier bit per clock and uses a start/busy/done handshake.
- Sits between an operand source, such as a control FSM or register file, and any consumer of a registered 2*WIDTH-bit product.

---
 rtl/seq_multiplier.sv | 106 ++++++++++
 tb/tb_seq_multiplier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, start/busy/done handshake.
// Optional two's-complement mode enabled by defining SEQ_MULT_SIGNED_EN (adds the sgn port).
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            neg_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_req;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    prod_final;

  // Signed mode multiplies magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag   = a;
    b_mag   = b;
    neg_req = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    if (sgn) begin
      if (a[WIDTH-1]) a_mag = ~a + 1'b1;
      if (b[WIDTH-1]) b_mag = ~b + 1'b1;
      neg_req = a[WIDTH-1] ^ b[WIDTH-1];
    end
`endif
  end

  always_comb begin
    acc_sum    = mplier[0] ? (acc + mcand) : acc;
    prod_final = neg_q ? (~acc_sum + 1'b1) : acc_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg_q  <= 1'b0;
    end else begin
      case (state)
        // DONE shares IDLE's accept path so back-to-back requests need no bubble.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            count  <= '0;
            neg_q  <= neg_req;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            result <= prod_final;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8 against an arithmetic reference.
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SGN_ON = 1'b1;
`else
  localparam bit SGN_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] prod;
    int          acc;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  r4;
  logic [15:0] r8;
`ifdef SEQ_MULT_SIGNED_EN
  logic        sg4, sg8;
`endif

  op_t         q4[$];
  op_t         q8[$];
  logic [15:0] last4, last8;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn(sg4),
`endif
    .busy(busy4), .done(done4), .result(r4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn(sg8),
`endif
    .busy(busy8), .done(done8), .result(r8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_prod(input int w, input logic [7:0] av,
                                           input logic [7:0] bv, input bit sv);
    longint ai, bi, p, m;
    m  = (longint'(1) << w) - 1;
    ai = longint'(av) & m;
    bi = longint'(bv) & m;
    if (sv && SGN_ON) begin
      if (ai >= (longint'(1) << (w - 1))) ai = ai - (longint'(1) << w);
      if (bi >= (longint'(1) << (w - 1))) bi = bi - (longint'(1) << w);
    end
    p = ai * bi;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Drive a one-edge start; if expect_acc, the request is accepted and enters the scoreboard.
  task automatic drive(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                       input bit sv, input bit expect_acc);
    op_t e;
    if (w8) begin
      start8 = 1'b1; a8 = av; b8 = bv;
`ifdef SEQ_MULT_SIGNED_EN
      sg8 = sv;
`endif
    end else begin
      start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
`ifdef SEQ_MULT_SIGNED_EN
      sg4 = sv;
`endif
    end
    @(posedge clk); #1;
    if (expect_acc) begin
      e.prod = exp_prod(w8 ? 8 : 4, av, bv, sv);
      e.acc  = cyc;
      if (w8) q8.push_back(e); else q4.push_back(e);
    end
    if (w8) begin
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    end else begin
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (q4.size() > 0 && cyc == q4[0].acc + 4) begin
      chk("done4", done4, 1);
      chk("busy4_at_done", busy4, 0);
      chk("result4", r4, q4[0].prod[7:0]);
      last4 = q4[0].prod;
      void'(q4.pop_front());
    end else begin
      chk("done4_quiet", done4, 0);
      chk("busy4", busy4, q4.size() > 0);
      chk("hold4", r4, last4[7:0]);
    end
  end

  always @(negedge clk) begin
    if (q8.size() > 0 && cyc == q8[0].acc + 8) begin
      chk("done8", done8, 1);
      chk("busy8_at_done", busy8, 0);
      chk("result8", r8, q8[0].prod);
      last8 = q8[0].prod;
      void'(q8.pop_front());
    end else begin
      chk("done8_quiet", done8, 0);
      chk("busy8", busy8, q8.size() > 0);
      chk("hold8", r8, last8);
    end
  end

  initial begin
    int gap;
    logic [7:0] ra, rb;
    bit rs;
    rst_n = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
`ifdef SEQ_MULT_SIGNED_EN
    sg4 = 1'b0; sg8 = 1'b0;
`endif
    last4 = '0; last8 = '0;
    #7;
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0); chk("rst_result4", r4, 0);
    chk("rst_busy8", busy8, 0); chk("rst_result8", r8, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 15*15, then back-to-back 10*0, 10*10, 1*9, 2*7
    drive(0, 8'd15, 8'd15, 0, 1);
    repeat (6) @(posedge clk); #1;
    drive(0, 8'd10, 8'd0, 0, 1);
    repeat (4) @(posedge clk); #1;
    drive(0, 8'd10, 8'd10, 0, 1);
    repeat (4) @(posedge clk); #1;
    drive(0, 8'd1, 8'd9, 0, 1);
    repeat (4) @(posedge clk); #1;
    drive(0, 8'd2, 8'd7, 0, 1);
    repeat (6) @(posedge clk); #1;

    // 255*255 with operands changed mid-operation
    drive(1, 8'd255, 8'd255, 0, 1);
    @(posedge clk); #1;
    a8 = 8'd3; b8 = 8'd3;
    repeat (9) @(posedge clk); #1;

    // start during CALC is ignored
    drive(0, 8'd5, 8'd3, 0, 1);
    @(posedge clk); #1;
    drive(0, 8'd7, 8'd7, 0, 0);
    repeat (6) @(posedge clk); #1;

    // reset in the 2nd CALC cycle aborts 6*6
    drive(0, 8'd6, 8'd6, 0, 1);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    q4.delete(); q8.delete();
    last4 = '0; last8 = '0;
    #1;
    chk("abort_busy4", busy4, 0); chk("abort_done4", done4, 0); chk("abort_result4", r4, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    drive(0, 8'd3, 8'd4, 0, 1);
    repeat (6) @(posedge clk); #1;

`ifdef SEQ_MULT_SIGNED_EN
    drive(0, 8'h08, 8'h07, 1, 1);
    repeat (5) @(posedge clk); #1;
    drive(0, 8'h0D, 8'h0B, 1, 1);
    repeat (5) @(posedge clk); #1;
    drive(0, 8'h0F, 8'h02, 0, 1);
    repeat (5) @(posedge clk); #1;
    drive(1, 8'h80, 8'h80, 1, 1);
    repeat (9) @(posedge clk); #1;
`endif

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (i % 4 == 0) ra = 8'h00;
      if (i % 5 == 0) rb = 8'hFF;
      gap = int'($urandom_range(0, 2));
      drive(i[0], ra, rb, rs, 1);
      repeat ((i[0] ? 8 : 4) + gap) @(posedge clk); #1;
    end

    repeat (12) @(posedge clk); #1;
    chk("drain4", q4.size(), 0);
    chk("drain8", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
